countupdown_stepper: RTL and testbench

- Generates the up/down edge trains that drive a preloadable up/down counter towards a commanded target value.
- Keeps an internal mirror of the downstream count and emits one clean pulse per step of `increment` on `pulse_up` or `pulse_dn`.
- Stops when the mirror is within one increment of the target.
- Sits upstream of the counter block in the timing chain, with outputs wired to that block's up/down clock inputs.

---
 rtl/countupdown_stepper.sv | 207 ++++++++++++++++++++
 tb/tb_countupdown_stepper.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/countupdown_stepper.sv
// Step-pulse generator that walks a downstream up/down counter to a target while mirroring its count.
// Optional build macro STEPPER_LIMIT_EN adds a per-move step limit (max_steps / limit_hit).
module countupdown_stepper #(
   parameter int unsigned WIDTH    = 16,
   parameter int unsigned PULSE_HI = 2,
   parameter int unsigned PULSE_LO = 2,
   parameter int unsigned TW       = 8
) (
   input  logic             clk_up,
   input  logic             reset,
   input  logic [WIDTH-1:0] preload,
   input  logic [WIDTH-1:0] increment,
   input  logic [WIDTH-1:0] target,
   input  logic             start,
   input  logic             abort,
   input  logic             resync,
`ifdef STEPPER_LIMIT_EN
   input  logic [WIDTH-1:0] max_steps,
   output logic             limit_hit,
`endif
   output logic             pulse_up,
   output logic             pulse_dn,
   output logic             busy,
   output logic             done,
   output logic             aborted,
   output logic [WIDTH-1:0] position
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_HIGH,
      S_LOW,
      S_DONE
   } state_e;

   localparam logic [TW-1:0] HI_LOAD = TW'(PULSE_HI - 1);
   localparam logic [TW-1:0] LO_LOAD = TW'(PULSE_LO - 1);

   state_e           state_q, state_d;
   logic [TW-1:0]    timer_q, timer_d;
   logic [WIDTH-1:0] pos_q, pos_d;
   logic [WIDTH-1:0] target_q, target_d;
   logic [WIDTH-1:0] inc_q, inc_d;
   logic             dir_dn_q, dir_dn_d;
   logic             abort_q, abort_d;
   logic             aborted_q, aborted_d;
   logic             pulse_up_q, pulse_up_d;
   logic             pulse_dn_q, pulse_dn_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;
`ifdef STEPPER_LIMIT_EN
   logic [WIDTH-1:0] step_q, step_d;
   logic [WIDTH-1:0] max_q, max_d;
   logic             limit_q, limit_d;
`endif

   // In IDLE the move decision uses the live inputs (and the resync-reloaded mirror);
   // mid-move it uses the values latched at start.
   logic             in_idle;
   logic [WIDTH-1:0] cmp_pos, cmp_tgt, cmp_inc;
   logic [WIDTH:0]   diff, remaining;
   logic             go_dn, rem_ok, abort_seen;

   assign in_idle    = (state_q == S_IDLE);
   assign cmp_pos    = (in_idle && resync) ? preload : pos_q;
   assign cmp_tgt    = in_idle ? target : target_q;
   assign cmp_inc    = in_idle ? increment : inc_q;
   assign diff       = {1'b0, cmp_tgt} - {1'b0, cmp_pos};
   assign go_dn      = diff[WIDTH];
   assign remaining  = go_dn ? -diff : diff;
   assign rem_ok     = (cmp_inc != '0) && (remaining >= {1'b0, cmp_inc});
   assign abort_seen = abort_q | abort;

   // NOTE: every variable gets its default before the case so no path leaves one unassigned (no latches).
   always_comb begin
      state_d   = state_q;
      timer_d   = timer_q;
      pos_d     = pos_q;
      target_d  = target_q;
      inc_d     = inc_q;
      dir_dn_d  = dir_dn_q;
      abort_d   = abort_q | (!in_idle && abort);
      aborted_d = aborted_q;
`ifdef STEPPER_LIMIT_EN
      step_d    = step_q;
      max_d     = max_q;
      limit_d   = limit_q;
`endif
      unique case (state_q)
         S_IDLE: begin
            if (resync) pos_d = preload;
            if (start) begin
               target_d  = target;
               inc_d     = increment;
               abort_d   = 1'b0;
               aborted_d = 1'b0;
`ifdef STEPPER_LIMIT_EN
               step_d    = '0;
               max_d     = max_steps;
               limit_d   = 1'b0;
`endif
               if (rem_ok) begin
                  state_d  = S_HIGH;
                  dir_dn_d = go_dn;
                  timer_d  = HI_LOAD;
               end else begin
                  state_d  = S_DONE;
               end
            end
         end
         S_HIGH: begin
            if (timer_q == '0) begin
               state_d = S_LOW;
               timer_d = LO_LOAD;
               pos_d   = dir_dn_q ? (pos_q - inc_q) : (pos_q + inc_q);
`ifdef STEPPER_LIMIT_EN
               step_d  = step_q + WIDTH'(1);
`endif
            end else begin
               timer_d = timer_q - TW'(1);
            end
         end
         S_LOW: begin
            if (timer_q == '0) begin
               if (abort_seen) begin
                  state_d   = S_DONE;
                  aborted_d = 1'b1;
               end
`ifdef STEPPER_LIMIT_EN
               else if ((max_q != '0) && (step_q == max_q)) begin
                  state_d = S_DONE;
                  limit_d = 1'b1;
               end
`endif
               else if (rem_ok) begin
                  state_d = S_HIGH;
                  timer_d = HI_LOAD;
               end else begin
                  state_d = S_DONE;
               end
            end else begin
               timer_d = timer_q - TW'(1);
            end
         end
         S_DONE: state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase

      // Outputs are registered copies of what the next state implies, so they change on the same edge.
      pulse_up_d = (state_d == S_HIGH) && !dir_dn_d;
      pulse_dn_d = (state_d == S_HIGH) && dir_dn_d;
      busy_d     = (state_d != S_IDLE);
      done_d     = (state_d == S_DONE);
   end

   // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
   always_ff @(posedge clk_up or posedge reset) begin
      if (reset) begin
         state_q    <= S_IDLE;
         timer_q    <= '0;
         pos_q      <= preload;  // downstream counter reloads the same preload on this shared reset
         target_q   <= '0;
         inc_q      <= '0;
         dir_dn_q   <= 1'b0;
         abort_q    <= 1'b0;
         aborted_q  <= 1'b0;
         pulse_up_q <= 1'b0;
         pulse_dn_q <= 1'b0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
`ifdef STEPPER_LIMIT_EN
         step_q     <= '0;
         max_q      <= '0;
         limit_q    <= 1'b0;
`endif
      end else begin
         state_q    <= state_d;
         timer_q    <= timer_d;
         pos_q      <= pos_d;
         target_q   <= target_d;
         inc_q      <= inc_d;
         dir_dn_q   <= dir_dn_d;
         abort_q    <= abort_d;
         aborted_q  <= aborted_d;
         pulse_up_q <= pulse_up_d;
         pulse_dn_q <= pulse_dn_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
`ifdef STEPPER_LIMIT_EN
         step_q     <= step_d;
         max_q      <= max_d;
         limit_q    <= limit_d;
`endif
      end
   end

   assign pulse_up = pulse_up_q;
   assign pulse_dn = pulse_dn_q;
   assign busy     = busy_q;
   assign done     = done_q;
   assign aborted  = aborted_q;
   assign position = pos_q;
`ifdef STEPPER_LIMIT_EN
   assign limit_hit = limit_q;
`endif

endmodule

// File: tb/tb_countupdown_stepper.sv
// Self-checking bench for countupdown_stepper: directed moves plus randomized moves
// compared every cycle against a step-count model of the move schedule.
module tb_countupdown_stepper;
   localparam int W = 16;
   localparam int H = 2;
   localparam int L = 2;
   localparam int P = H + L;

   logic         clk_up = 1'b0;
   logic         reset;
   logic [W-1:0] preload, increment, target;
   logic         start, abort, resync;
   logic         pulse_up, pulse_dn, busy, done, aborted;
   logic [W-1:0] position;
`ifdef STEPPER_LIMIT_EN
   logic [W-1:0] max_steps;
   logic         limit_hit;
`endif

   countupdown_stepper #(.WIDTH(W), .PULSE_HI(H), .PULSE_LO(L), .TW(8)) dut (
      .clk_up    (clk_up),
      .reset     (reset),
      .preload   (preload),
      .increment (increment),
      .target    (target),
      .start     (start),
      .abort     (abort),
      .resync    (resync),
`ifdef STEPPER_LIMIT_EN
      .max_steps (max_steps),
      .limit_hit (limit_hit),
`endif
      .pulse_up  (pulse_up),
      .pulse_dn  (pulse_dn),
      .busy      (busy),
      .done      (done),
      .aborted   (aborted),
      .position  (position)
   );

   always #5 clk_up = ~clk_up;

   int n_checks = 0;
   int n_pass   = 0;

   // Model of the current/last move: it starts at m_acc, performs m_steps steps of m_inc
   // in direction m_dir from m_pos0; outside a move the mirror rests at m_rest_pos.
   int cyc        = 0;
   bit m_moving   = 1'b0;
   int m_acc      = 0;
   int m_steps    = 0;
   int m_dir      = 1;
   int m_pos0     = 0;
   int m_inc      = 0;
   int m_rest_pos = 0;
   bit m_ab       = 1'b0;
   bit m_lim      = 1'b0;

   int up_rises = 0, dn_rises = 0, up_cycles = 0, done_cyc = -1;
   bit prev_up = 1'b0, prev_dn = 1'b0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
   endtask

   task automatic compare_cycle();
      int c, end_c, k, e_pos;
      bit e_up, e_dn, e_busy, e_done, e_ab, e_lim, in_p;
      c     = cyc - m_acc;
      end_c = m_steps * P;
      if (m_moving && c >= 0 && c <= end_c) begin
         in_p   = (c < end_c) && ((c % P) < H);
         e_up   = in_p && (m_dir > 0);
         e_dn   = in_p && (m_dir < 0);
         e_busy = 1'b1;
         e_done = (c == end_c);
         k      = (c < H) ? 0 : ((c - H) / P + 1);
         if (k > m_steps) k = m_steps;
         e_pos  = m_pos0 + m_dir * m_inc * k;
         e_ab   = e_done && m_ab;
         e_lim  = e_done && m_lim;
      end else begin
         e_up = 1'b0; e_dn = 1'b0; e_busy = 1'b0; e_done = 1'b0;
         e_pos = m_rest_pos; e_ab = m_ab; e_lim = m_lim;
      end
      check("cmp pulse_up", pulse_up, e_up);
      check("cmp pulse_dn", pulse_dn, e_dn);
      check("cmp busy", busy, e_busy);
      check("cmp done", done, e_done);
      check("cmp aborted", aborted, e_ab);
      check("cmp position", position, e_pos);
`ifdef STEPPER_LIMIT_EN
      check("cmp limit_hit", limit_hit, e_lim);
`endif
      if (pulse_up && !prev_up) up_rises++;
      if (pulse_dn && !prev_dn) dn_rises++;
      if (pulse_up) up_cycles++;
      if (done) done_cyc = cyc;
      prev_up = pulse_up;
      prev_dn = pulse_dn;
   endtask

   // Compare on the falling edge, then advance to just after the next rising edge.
   task automatic tick();
      @(negedge clk_up);
      compare_cycle();
      @(posedge clk_up);
      cyc++;
      #1;
   endtask

   task automatic do_reset(input int pl);
      preload = W'(pl);
      reset   = 1'b1;
      m_moving = 1'b0; m_rest_pos = pl; m_ab = 1'b0; m_lim = 1'b0;
      tick();
      tick();
      reset = 1'b0;
   endtask

   task automatic do_resync(input int pl);
      preload = W'(pl);
      resync  = 1'b1;
      tick();
      resync  = 1'b0;
      m_rest_pos = pl;
   endtask

   // ab_c < 0: no abort; otherwise abort is held for move cycle ab_c only.
   task automatic do_move(input int tgt, input int inc, input int ab_c, input bit rs,
                          input int mx, input bit junk);
      int pos0, d, n, s, dir;
      bit ab, lim;
      pos0 = rs ? int'(preload) : m_rest_pos;
      d    = tgt - pos0;
      dir  = (d < 0) ? -1 : 1;
      if (d < 0) d = -d;
      n    = (inc == 0) ? 0 : d / inc;
      s    = n; ab = 1'b0; lim = 1'b0;
`ifdef STEPPER_LIMIT_EN
      if (mx != 0 && mx <= n) begin s = mx; lim = 1'b1; end
`endif
      if (ab_c >= 0 && (ab_c / P + 1) <= s) begin s = ab_c / P + 1; ab = 1'b1; lim = 1'b0; end
      target    = W'(tgt);
      increment = W'(inc);
      resync    = rs;
      start     = 1'b1;
`ifdef STEPPER_LIMIT_EN
      max_steps = W'(mx);
`endif
      tick();
      start = 1'b0; resync = 1'b0;
      m_pos0 = pos0; m_dir = dir; m_inc = inc; m_steps = s; m_ab = ab; m_lim = lim;
      m_rest_pos = pos0 + dir * inc * s;
      m_acc = cyc; m_moving = 1'b1;
      for (int c = 0; c <= s * P; c++) begin
         abort = (c == ab_c);
         if (junk && c == 1) begin
            start     = 1'b1;
            target    = W'($urandom);
            increment = W'($urandom_range(1, 50));
         end else begin
            start = 1'b0;
         end
         tick();
      end
      abort = 1'b0;
   endtask

   int ur, dr, uc;

   task automatic snap();
      ur = up_rises; dr = dn_rises; uc = up_cycles;
   endtask

   initial begin
      int base, tgt, inc, ab_c, mx;
      bit rs;
      start = 1'b0; abort = 1'b0; resync = 1'b0;
      increment = '0; target = '0;
`ifdef STEPPER_LIMIT_EN
      max_steps = '0;
`endif
      do_reset(100);
      check("reset position", position, 100);
      check("reset busy", busy, 0);
      check("reset pulse_up", pulse_up, 0);
      check("reset done", done, 0);

      // 100 -> 130 by 10: pulses on move cycles 0-1, 4-5, 8-9; done on cycle 12.
      snap();
      do_move(130, 10, -1, 0, 0, 0);
      check("up3 pulses", up_rises - ur, 3);
      check("up3 high cycles", up_cycles - uc, 6);
      check("up3 no dn", dn_rises - dr, 0);
      check("up3 done cycle", done_cyc - m_acc, 12);
      check("up3 position", position, 130);

      do_resync(100);
      snap();
      do_move(125, 10, -1, 0, 0, 0);
      check("up2 pulses", up_rises - ur, 2);
      check("up2 position", position, 120);
      check("up2 aborted", aborted, 0);

      do_resync(100);
      snap();
      do_move(70, 10, -1, 0, 0, 0);
      check("dn3 pulses", dn_rises - dr, 3);
      check("dn3 no up", up_rises - ur, 0);
      check("dn3 position", position, 70);

      snap();
      do_move(500, 0, -1, 0, 0, 0);
      check("inc0 pulses", up_rises - ur, 0);
      check("inc0 done cycle", done_cyc - m_acc, 0);
      check("inc0 position", position, 70);
      do_move(70, 10, -1, 0, 0, 0);
      check("same done cycle", done_cyc - m_acc, 0);
      check("same position", position, 70);

      // Abort during the first pulse: that step completes, then the move ends.
      do_resync(100);
      snap();
      do_move(200, 10, 1, 0, 0, 0);
      check("abort pulses", up_rises - ur, 1);
      check("abort done cycle", done_cyc - m_acc, 4);
      check("abort position", position, 110);
      check("abort flag held", aborted, 1);

      // resync with start: move begins from the new preload.
      preload = 16'd50;
      snap();
      do_move(80, 10, -1, 1, 0, 0);
      check("rs+start position", position, 80);
      check("rs+start pulses", up_rises - ur, 3);
      check("rs+start aborted cleared", aborted, 0);

      // Restart and input changes mid-move must be ignored.
      snap();
      do_move(20, 15, -1, 0, 0, 1);
      check("busy start pulses", dn_rises - dr, 4);
      check("busy start position", position, 20);

      // Reset in the middle of a pulse_up high phase.
      do_resync(100);
      target = 16'd200; increment = 16'd10; start = 1'b1;
      tick();
      start = 1'b0;
      m_pos0 = 100; m_dir = 1; m_inc = 10; m_steps = 10; m_ab = 1'b0; m_lim = 1'b0;
      m_rest_pos = 200; m_acc = cyc; m_moving = 1'b1;
      tick();
      #2;
      reset = 1'b1;
      m_moving = 1'b0; m_rest_pos = 100;
      #1;
      check("rst mid pulse_up", pulse_up, 0);
      check("rst mid busy", busy, 0);
      check("rst mid position", position, 100);
      tick();
      tick();
      reset = 1'b0;
      tick();

`ifdef STEPPER_LIMIT_EN
      do_resync(100);
      snap();
      do_move(200, 10, -1, 0, 2, 0);
      check("limit pulses", up_rises - ur, 2);
      check("limit position", position, 120);
      check("limit_hit held", limit_hit, 1);
`endif

      for (int it = 0; it < 40; it++) begin
         rs = ($urandom_range(0, 3) == 0);
         if (rs) preload = W'($urandom_range(0, 65535));
         base = rs ? int'(preload) : m_rest_pos;
         inc  = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, 300));
         tgt  = base + int'($urandom_range(0, 2 * (7 * inc + 100))) - (7 * inc + 100);
         if (tgt < 0) tgt = 0;
         if (tgt > 65535) tgt = 65535;
         ab_c = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, 30)) : -1;
         mx   = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 5)) : 0;
         do_move(tgt, inc, ab_c, rs, mx, $urandom_range(0, 3) == 0);
         if ($urandom_range(0, 1) == 1) tick();
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
